baud_tick_ctrl: RTL and testbench

Runtime-configurable baud tick scheduler for the UART datapath on the iCE40 tester, clocked from hwclk.
- Generates a 1-cycle oversample strobe (rx_tick) every active_div hwclk cycles, and a bit strobe (tx_tick) every OVERSAMPLE rx_ticks.
- Accepts new divisor values over a valid/ready handshake.
- Defers divisor changes to a bit boundary so no UART bit is ever stretched or truncated.

---
 rtl/baud_tick_ctrl.sv | 153 +++++++++++++++
 tb/tb_baud_tick_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_ctrl.sv
// ============================================================================
//  Module      : baud_tick_ctrl
//  Description : Runtime-configurable UART baud tick scheduler. Emits an
//                oversample strobe every active_div cycles and a bit strobe
//                every OVERSAMPLE oversample strobes. Divisor changes offered
//                while running are deferred to the next bit boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_ctrl #(
    parameter int CNTR_W      = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 78
) (
    input  logic              hwclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [CNTR_W-1:0] cfg_div,
    output logic              cfg_ready,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic [CNTR_W-1:0] active_div,
    output logic              busy
);

    localparam int                OS_W        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]   c_OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [CNTR_W-1:0] c_DEF_DIV   = CNTR_W'(DEFAULT_DIV);
    localparam logic [CNTR_W-1:0] c_MIN_DIV   = CNTR_W'(2);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]        r_state,       w_state_nxt;
    logic [CNTR_W-1:0] r_div_cnt,     w_div_cnt_nxt;
    logic [OS_W-1:0]   r_os_cnt,      w_os_cnt_nxt;
    logic [CNTR_W-1:0] r_active_div,  w_active_div_nxt;
    logic [CNTR_W-1:0] r_pending_div, w_pending_div_nxt;
    logic              r_pending,     w_pending_nxt;
    logic              r_rx_tick,     w_rx_tick_nxt;
    logic              r_tx_tick,     w_tx_tick_nxt;
    logic              r_cfg_ready,   w_cfg_ready_nxt;
    logic              r_busy,        w_busy_nxt;

    logic              w_xfer;
    logic [CNTR_W-1:0] w_cfg_clamped;

    assign w_xfer        = cfg_valid && r_cfg_ready;
    assign w_cfg_clamped = (cfg_div < c_MIN_DIV) ? c_MIN_DIV : cfg_div;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_div_cnt     <= '0;
            r_os_cnt      <= '0;
            r_active_div  <= c_DEF_DIV;
            r_pending_div <= '0;
            r_pending     <= 1'b0;
            r_rx_tick     <= 1'b0;
            r_tx_tick     <= 1'b0;
            r_cfg_ready   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_div_cnt     <= w_div_cnt_nxt;
            r_os_cnt      <= w_os_cnt_nxt;
            r_active_div  <= w_active_div_nxt;
            r_pending_div <= w_pending_div_nxt;
            r_pending     <= w_pending_nxt;
            r_rx_tick     <= w_rx_tick_nxt;
            r_tx_tick     <= w_tx_tick_nxt;
            r_cfg_ready   <= w_cfg_ready_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_div_cnt_nxt     = r_div_cnt;
        w_os_cnt_nxt      = r_os_cnt;
        w_active_div_nxt  = r_active_div;
        w_pending_div_nxt = r_pending_div;
        w_pending_nxt     = r_pending;
        w_rx_tick_nxt     = 1'b0;
        w_tx_tick_nxt     = 1'b0;
        w_cfg_ready_nxt   = r_cfg_ready;

        case (r_state)
            c_IDLE: begin
                w_div_cnt_nxt = '0;
                w_os_cnt_nxt  = '0;
                if (w_xfer)
                    w_active_div_nxt = w_cfg_clamped;
                if (enable)
                    w_state_nxt = c_RUN;
            end

            default: begin
                if (!enable) begin
                    // Stopping is a bit boundary too: flush any deferred divisor.
                    w_state_nxt   = c_IDLE;
                    w_div_cnt_nxt = '0;
                    w_os_cnt_nxt  = '0;
                    if (r_pending) begin
                        w_active_div_nxt = r_pending_div;
                        w_pending_nxt    = 1'b0;
                        w_cfg_ready_nxt  = 1'b1;
                    end
                    if (w_xfer)
                        w_active_div_nxt = w_cfg_clamped;
                end else begin
                    if (r_div_cnt == r_active_div - 1'b1) begin
                        w_div_cnt_nxt = '0;
                        w_rx_tick_nxt = 1'b1;
                        if (r_os_cnt == c_OS_LAST) begin
                            w_os_cnt_nxt  = '0;
                            w_tx_tick_nxt = 1'b1;
                            if (r_pending) begin
                                w_active_div_nxt = r_pending_div;
                                w_pending_nxt    = 1'b0;
                                w_cfg_ready_nxt  = 1'b1;
                            end
                        end else begin
                            w_os_cnt_nxt = r_os_cnt + 1'b1;
                        end
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + 1'b1;
                    end
                    // A transfer needs cfg_ready, so no pending value can be
                    // consumed on this edge; the new one waits a full bit.
                    if (w_xfer) begin
                        w_pending_div_nxt = w_cfg_clamped;
                        w_pending_nxt     = 1'b1;
                        w_cfg_ready_nxt   = 1'b0;
                    end
                end
            end
        endcase

        w_busy_nxt = (w_state_nxt == c_RUN);
    end

    assign cfg_ready  = r_cfg_ready;
    assign rx_tick    = r_rx_tick;
    assign tx_tick    = r_tx_tick;
    assign active_div = r_active_div;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_ctrl.sv
// ============================================================================
//  Module      : tb_baud_tick_ctrl
//  Description : Self-checking bench for baud_tick_ctrl against an
//                elapsed-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_tick_ctrl;

    localparam int c_CNTR_W = 16;
    localparam int c_OS     = 16;
    localparam int c_DEF    = 78;

    logic              hwclk = 1'b0;
    logic              rst;
    logic              enable;
    logic              cfg_valid;
    logic [c_CNTR_W-1:0] cfg_div;
    logic              cfg_ready;
    logic              rx_tick;
    logic              tx_tick;
    logic [c_CNTR_W-1:0] active_div;
    logic              busy;

    baud_tick_ctrl #(
        .CNTR_W      (c_CNTR_W),
        .OVERSAMPLE  (c_OS),
        .DEFAULT_DIV (c_DEF)
    ) u_dut (
        .hwclk      (hwclk),
        .rst        (rst),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .rx_tick    (rx_tick),
        .tx_tick    (tx_tick),
        .active_div (active_div),
        .busy       (busy)
    );

    always #5 hwclk = ~hwclk;

    int total = 0;
    int bad   = 0;

    // Reference model: ticks derived from cycles elapsed since the segment start
    bit     m_run, m_pend, m_ready, m_rx, m_tx;
    int     m_d, m_pdiv;
    longint n, seg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_ready = 1; m_rx = 0; m_tx = 0;
        m_d = c_DEF; m_pdiv = 0; n = 0; seg = 0;
    endtask

    function automatic bit tx_next();
        longint k;
        if (!m_run || !enable) return 1'b0;
        k = n + 1 - seg;
        return (k % m_d == 0) && ((k / m_d) % c_OS == 0);
    endfunction

    task automatic step();
        bit     xfer;
        longint k;
        n++;
        xfer = cfg_valid && m_ready;
        m_rx = 0; m_tx = 0;
        if (!m_run) begin
            if (xfer) m_d = clampd(int'(cfg_div));
            if (enable) begin m_run = 1; seg = n; end
        end else if (!enable) begin
            m_run = 0;
            if (m_pend) begin m_d = m_pdiv; m_pend = 0; m_ready = 1; end
            if (xfer) m_d = clampd(int'(cfg_div));
        end else begin
            k    = n - seg;
            m_rx = (k % m_d == 0);
            m_tx = m_rx && ((k / m_d) % c_OS == 0);
            if (m_tx && m_pend) begin
                m_d = m_pdiv; m_pend = 0; m_ready = 1; seg = n;
            end
            if (xfer) begin m_pend = 1; m_pdiv = clampd(int'(cfg_div)); m_ready = 0; end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".rx"},    32'(rx_tick),    32'(m_rx));
        chk({ph, ".tx"},    32'(tx_tick),    32'(m_tx));
        chk({ph, ".ready"}, 32'(cfg_ready),  32'(m_ready));
        chk({ph, ".busy"},  32'(busy),       32'(m_run));
        chk({ph, ".div"},   32'(active_div), 32'(m_d));
    endtask

    task automatic cyc(input string ph);
        @(posedge hwclk);
        step();
        #1;
        check_all(ph);
    endtask

    initial begin
        int hits;
        int guard;

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        #12;
        check_all("reset");
        repeat (2) @(posedge hwclk);
        #1 rst = 1'b0;

        repeat (200) cyc("idle");

        // Default-divisor run with a deferred change offered mid-bit
        enable = 1'b1;
        for (int i = 0; i < 1400; i++) begin
            cfg_valid = (i == 300);
            cfg_div   = 16'd10;
            cyc("run78");
        end
        cfg_valid = 1'b0;

        // Clamp checks in IDLE
        enable = 1'b0; cyc("stop");
        cyc("stop");
        cfg_valid = 1'b1; cfg_div = 16'd0; cyc("clamp0");
        cfg_div = 16'd1; cyc("clamp1");
        cfg_valid = 1'b0;
        enable = 1'b1;
        repeat (100) cyc("div2");

        for (int i = 0; i < 15000; i++) begin
            if ($urandom % 300 == 0) enable = ~enable;
            cfg_valid = ($urandom % 30 == 0);
            cfg_div   = 16'($urandom_range(0, 9));
            cyc("rand");
        end

        // Offers landing exactly on tx_tick-generating edges
        enable = 1'b1; cfg_valid = 1'b0;
        guard = 0;
        while ((!m_ready || !m_run) && guard < 3000) begin cyc("drain"); guard++; end
        hits = 0; guard = 0;
        while (hits < 3 && guard < 5000) begin
            cfg_valid = tx_next() && m_ready;
            cfg_div   = 16'($urandom_range(3, 6));
            if (cfg_valid) hits++;
            cyc("coinc");
            guard++;
        end
        cfg_valid = 1'b0;
        chk("coinc_hits", 32'(hits >= 3), 32'd1);
        repeat (400) cyc("coinc_after");

        // Asynchronous reset mid-run with a divisor pending
        guard = 0;
        while (!m_ready && guard < 3000) begin cyc("pre_rst"); guard++; end
        cfg_valid = 1'b1; cfg_div = 16'd7; cyc("pend");
        cfg_valid = 1'b0;
        repeat (5) cyc("pend_hold");
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        enable = 1'b0;
        repeat (2) @(posedge hwclk);
        #1 rst = 1'b0;
        repeat (50) cyc("post_rst");
        enable = 1'b1;
        repeat (300) cyc("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
